odd_even_merger: RTL and testbench

//  Consumer end of the column-wise odd/even index split. The even lane (idx 0,2,4..) and the
//  odd lane (idx 1,3,5..) each deliver tagged results; this block re-interleaves them into one
//  in-order stream 0,1,2,..,num_cols-1.

---
 rtl/sdmm_pkg.sv | 14 +
 rtl/merge_out_reg.sv | 43 ++++
 rtl/odd_even_merger.sv | 114 +++++++++++
 tb/tb_odd_even_merger.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdmm_pkg.sv
// Shared types and default sizing for the odd/even column split and merge path.
// Holds the merger FSM state encoding and the lane counter and data widths.
package sdmm_pkg;

    localparam int COUNT_LEN_DEF = 10;
    localparam int DATA_W_DEF    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/merge_out_reg.sv
// Single-entry output register for the merged stream.
// It loads on a lane accept, holds while stalled and clears when the downstream handshake completes.
module merge_out_reg
    import sdmm_pkg::*;
#(
    parameter int IDX_W  = COUNT_LEN_DEF + 1,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_idx,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;

    // A load only happens when the slot is free, so it may overlap the draining handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_idx   <= i_idx;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_data  = r_data;

endmodule

// File: rtl/odd_even_merger.sv
// Re-interleaves the even-index and odd-index lane results into one in-order column stream.
// Handshakes: a transfer happens on a rising edge where valid && ready; a valid source holds its data until it is taken.
module odd_even_merger
    import sdmm_pkg::*;
#(
    parameter int COUNT_LEN = COUNT_LEN_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COUNT_LEN:0]  num_cols,
    input  logic                even_valid,
    input  logic [COUNT_LEN:0]  even_idx,
    input  logic [DATA_W-1:0]   even_data,
    output logic                even_ready,
    input  logic                odd_valid,
    input  logic [COUNT_LEN:0]  odd_idx,
    input  logic [DATA_W-1:0]   odd_data,
    output logic                odd_ready,
    output logic                out_valid,
    output logic [COUNT_LEN:0]  out_idx,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                seq_err,
    output state_t              dbg_state
);

    localparam int            CW  = COUNT_LEN + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_exp_idx;
    logic [CW-1:0]       r_num_cols_q;
    logic                r_seq_err;

    logic                w_slot_free;
    logic                w_more;
    logic                w_run;
    logic                w_load;
    logic                w_last_out;
    logic                w_start_ok;
    logic [CW-1:0]       w_lane_idx;
    logic [DATA_W-1:0]   w_lane_data;

    assign w_run       = (r_state == RUN);
    assign w_slot_free = !out_valid || out_ready;
    assign w_more      = (r_exp_idx < r_num_cols_q);
    assign w_start_ok  = (r_state == IDLE) && start;

    // Only the lane owning the parity of the expected index is ever offered ready.
    assign even_ready  = w_run && !r_exp_idx[0] && w_more && w_slot_free;
    assign odd_ready   = w_run &&  r_exp_idx[0] && w_more && w_slot_free;
    assign w_load      = (even_valid && even_ready) || (odd_valid && odd_ready);
    assign w_lane_idx  = r_exp_idx[0] ? odd_idx  : even_idx;
    assign w_lane_data = r_exp_idx[0] ? odd_data : even_data;

    // Once every element is accepted the register can only hold the last one.
    assign w_last_out  = out_valid && out_ready && (r_exp_idx == r_num_cols_q);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (num_cols == '0) ? DONE : RUN;
            RUN:     if (w_last_out) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_exp_idx    <= '0;
            r_num_cols_q <= '0;
            r_seq_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_exp_idx    <= '0;
                r_num_cols_q <= num_cols;
                r_seq_err    <= 1'b0;
            end else if (w_load) begin
                r_exp_idx <= r_exp_idx + ONE;
                if (w_lane_idx != r_exp_idx) r_seq_err <= 1'b1;
            end
        end
    end

    // The element is forwarded under the expected index even when its tag disagrees.
    merge_out_reg #(
        .IDX_W  (CW),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_idx   (r_exp_idx),
        .i_data  (w_lane_data),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_idx   (out_idx),
        .o_data  (out_data)
    );

    assign busy      = w_run;
    assign done      = (r_state == DONE);
    assign seq_err   = r_seq_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_odd_even_merger.sv
// Bench for odd_even_merger: random lane data and random stalls compared against an
// in-order stream model built from the lane contents of each pass.
module tb_odd_even_merger;
    import sdmm_pkg::*;

    localparam int CW  = 11;
    localparam int DW  = 32;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_cols = '0;
    logic          even_valid = 1'b0;
    logic [CW-1:0] even_idx = '0;
    logic [DW-1:0] even_data = '0;
    logic          even_ready;
    logic          odd_valid = 1'b0;
    logic [CW-1:0] odd_idx = '0;
    logic [DW-1:0] odd_data = '0;
    logic          odd_ready;
    logic          out_valid;
    logic [CW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          seq_err;
    state_t        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] even_tag_q[$];
    logic [CW-1:0] odd_tag_q[$];
    logic [DW-1:0] even_data_q[$];
    logic [DW-1:0] odd_data_q[$];

    always #5 clk = ~clk;

    odd_even_merger #(.COUNT_LEN(CW - 1), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_cols   (num_cols),
        .even_valid (even_valid),
        .even_idx   (even_idx),
        .even_data  (even_data),
        .even_ready (even_ready),
        .odd_valid  (odd_valid),
        .odd_idx    (odd_idx),
        .odd_data   (odd_data),
        .odd_ready  (odd_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .seq_err    (seq_err),
        .dbg_state  (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string where);
        chk({where, "_out_valid"}, out_valid, 0);
        chk({where, "_out_idx"}, out_idx, 0);
        chk({where, "_out_data"}, out_data, 0);
        chk({where, "_even_ready"}, even_ready, 0);
        chk({where, "_odd_ready"}, odd_ready, 0);
        chk({where, "_busy"}, busy, 0);
        chk({where, "_done"}, done, 0);
        chk({where, "_seq_err"}, seq_err, 0);
    endtask

    // Lane k%2 carries element k; the merged stream is simply the data in index order.
    task automatic build_pass(input int n, input int bad_pos);
        logic [DW-1:0] d;
        logic [CW-1:0] tag;
        exp_q.delete();
        even_tag_q.delete();
        odd_tag_q.delete();
        even_data_q.delete();
        odd_data_q.delete();
        for (int k = 0; k < n; k++) begin
            d   = $urandom();
            tag = (k == bad_pos) ? CW'(k + 2) : CW'(k);
            if (k % 2 == 0) begin
                even_tag_q.push_back(tag);
                even_data_q.push_back(d);
            end else begin
                odd_tag_q.push_back(tag);
                odd_data_q.push_back(d);
            end
            exp_q.push_back(d);
        end
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start    = 1'b1;
        num_cols = CW'(n);
        @(negedge clk);
        start    = 1'b0;
    endtask

    // rmode: 0 ready always, 1 toggling, 2 random. vmode: 0 lanes always valid, 1 random gaps.
    task automatic run_pass(input int n, input int bad_pos, input int rmode, input int vmode,
                            input int abort_after, input bit poke_start);
        int            out_cnt;
        int            acc_cnt;
        int            cyc;
        int            first_fire;
        int            last_fire;
        logic          exp_err;
        logic          stall;
        logic          ev_pend;
        logic          od_pend;
        logic          ev_fire;
        logic          od_fire;
        logic [CW-1:0] s_idx;
        logic [DW-1:0] s_data;
        logic [DW-1:0] want;
        out_cnt = 0; acc_cnt = 0; cyc = 0; first_fire = -1; last_fire = -1;
        exp_err = 1'b0; stall = 1'b0; ev_pend = 1'b0; od_pend = 1'b0;
        s_idx = '0; s_data = '0;
        build_pass(n, bad_pos);
        pulse_start(n);
        while (out_cnt < n && out_cnt < abort_after && cyc < 30 * n + 50) begin
            chk("busy_in_run", busy, 1);
            chk("state_in_run", dbg_state, RUN);
            chk("done_in_run", done, 0);
            chk("seq_err", seq_err, exp_err);
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_idx", out_idx, s_idx);
                chk("stall_data", out_data, s_data);
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start    = poke_start && (cyc == 2);
            num_cols = CW'($urandom_range(1, 40));
            if (!ev_pend)
                even_valid = (even_tag_q.size() > 0) && (vmode == 0 || $urandom_range(0, 2) != 0);
            if (!od_pend)
                odd_valid = (odd_tag_q.size() > 0) && (vmode == 0 || $urandom_range(0, 2) != 0);
            if (even_tag_q.size() > 0) begin
                even_idx  = even_tag_q[0];
                even_data = even_data_q[0];
            end
            if (odd_tag_q.size() > 0) begin
                odd_idx  = odd_tag_q[0];
                odd_data = odd_data_q[0];
            end
            #1;
            chk("ready_exclusive", even_ready && odd_ready, 0);
            chk("even_ready_turn", even_ready && (acc_cnt % 2 != 0 || acc_cnt >= n), 0);
            chk("odd_ready_turn", odd_ready && (acc_cnt % 2 != 1 || acc_cnt >= n), 0);
            chk("stall_no_ready", out_valid && !out_ready && (even_ready || odd_ready), 0);
            ev_fire = even_valid && even_ready;
            od_fire = odd_valid && odd_ready;
            if (ev_fire) begin
                if (even_tag_q[0] != CW'(acc_cnt)) exp_err = 1'b1;
                void'(even_tag_q.pop_front());
                void'(even_data_q.pop_front());
                acc_cnt++;
            end
            if (od_fire) begin
                if (odd_tag_q[0] != CW'(acc_cnt)) exp_err = 1'b1;
                void'(odd_tag_q.pop_front());
                void'(odd_data_q.pop_front());
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", 1, 0);
                end else begin
                    want = exp_q.pop_front();
                    chk("out_idx", out_idx, CW'(out_cnt));
                    chk("out_data", out_data, want);
                end
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                out_cnt++;
            end
            stall   = out_valid && !out_ready;
            s_idx   = out_idx;
            s_data  = out_data;
            ev_pend = even_valid && !ev_fire;
            od_pend = odd_valid && !od_fire;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (out_cnt < n && out_cnt < abort_after) chk("pass_timeout", 1, 0);
        if (out_cnt >= n) begin
            even_valid = 1'b0;
            odd_valid  = 1'b0;
            chk("done_pulse", done, 1);
            chk("busy_after_last", busy, 0);
            chk("out_valid_after_last", out_valid, 0);
            chk("seq_err_end", seq_err, exp_err);
            chk("ready_in_done", even_ready || odd_ready, 0);
            if (rmode == 0 && vmode == 0)
                chk("full_throughput", 64'(last_fire - first_fire), 64'(n - 1));
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("state_idle", dbg_state, IDLE);
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        chk("reset_state", dbg_state, IDLE);
        reset = 1'b1;

        // In-order lanes at full rate.
        run_pass(4, -1, 0, 0, BIG, 1'b0);

        // Both lanes always valid with a toggling downstream.
        run_pass(6, -1, 1, 0, BIG, 1'b0);

        // Odd lane tags element 3 as 5: flag sticks, stream continues in order.
        run_pass(8, 3, 2, 1, BIG, 1'b0);

        // Empty pass: straight to DONE, no data, start clears the sticky flag.
        pulse_start(0);
        chk("empty_done", done, 1);
        chk("empty_busy", busy, 0);
        chk("empty_out_valid", out_valid, 0);
        chk("empty_seq_err_cleared", seq_err, 0);
        @(negedge clk);
        chk("empty_done_drop", done, 0);
        chk("empty_busy_late", busy, 0);
        chk("empty_out_valid_late", out_valid, 0);

        // Reset in the middle of an 8-column pass, then a short clean pass.
        run_pass(8, -1, 0, 0, 3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midpass_reset");
        even_valid = 1'b0;
        odd_valid  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_pass(2, -1, 0, 0, BIG, 1'b0);

        // Odd column count ends on the even lane; a start during RUN must be ignored.
        run_pass(7, -1, 2, 1, BIG, 1'b1);

        for (int p = 0; p < 5; p++) begin
            int n;
            n = $urandom_range(1, 24);
            run_pass(n, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                     $urandom_range(0, 2), $urandom_range(0, 1), BIG, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
